dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage and the line-wide data memory. Serves word loads and byte-masked stores from an internal line array. On a miss it raises `stall`, writes back a dirty victim line and fetches the missing line, then completes the access. Downstream memory is line-addressed, reads combinationally, and writes one full line per clock on `wr_en`.

---
 rtl/dcache_ctrl_if.sv | 34 +++
 rtl/dcache_ctrl.sv | 138 +++++++++++++
 tb/tb_dcache_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: request/response and line-memory signals of the data cache.
// Ports: req_* / rd_data / stall face the MEM stage; mem_* face line memory;
//        hit_count / miss_count are statistics. master = pipeline+memory side, slave = cache.
interface dcache_ctrl_if #(
  parameter int LINE_SIZE   = 16,
  parameter int BYTE_COUNT  = 1024,
  parameter int CACHE_LINES = 8
);
  localparam int MEM_ADDR = $clog2(BYTE_COUNT / LINE_SIZE);

  logic                   req_valid;
  logic                   req_write;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic [3:0]             req_wstrb;
  logic [31:0]            rd_data;
  logic                   stall;
  logic [MEM_ADDR-1:0]    mem_addr;
  logic                   mem_wr_en;
  logic [LINE_SIZE*8-1:0] mem_wr_data;
  logic [LINE_SIZE*8-1:0] mem_rd_data;
  logic [31:0]            hit_count;
  logic [31:0]            miss_count;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, mem_rd_data,
    input  rd_data, stall, mem_addr, mem_wr_en, mem_wr_data, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, mem_rd_data,
    output rd_data, stall, mem_addr, mem_wr_en, mem_wr_data, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate data cache controller.
// Latency: hits complete in the request cycle; clean miss stalls 2 cycles, dirty miss 3.
// Backpressure: stall holds the MEM stage; requester must keep req_* stable while stall=1.
// Ports: clk, rst (sync, active-high), bus (dcache_ctrl_if.slave).
module dcache_ctrl #(
  parameter int LINE_SIZE   = 16,
  parameter int BYTE_COUNT  = 1024,
  parameter int CACHE_LINES = 8
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.slave  bus
);
  localparam int OFF_BITS = $clog2(LINE_SIZE);
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int MEM_ADDR = $clog2(BYTE_COUNT / LINE_SIZE);
  localparam int TAG_BITS = MEM_ADDR - IDX_BITS;
  localparam int LINE_W   = LINE_SIZE * 8;

  typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e                state_q, state_d;
  logic [CACHE_LINES-1:0] valid_q, valid_d;
  logic [CACHE_LINES-1:0] dirty_q, dirty_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic [TAG_BITS-1:0]   tag_q  [CACHE_LINES];
  logic [LINE_W-1:0]     data_q [CACHE_LINES];

  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [OFF_BITS+2:0]   bit_off;
  logic                  hit;
  logic                  hit_cmp;
  logic                  miss_cmp;
  logic                  store_hit;
  logic                  fill;
  logic [LINE_W-1:0]     line_d;
  logic                  unused_addr;

  assign idx     = bus.req_addr[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign req_tag = bus.req_addr[OFF_BITS+MEM_ADDR-1:OFF_BITS+IDX_BITS];
  // Bit position of the selected word inside the line; byte bits [1:0] are masked off.
  assign bit_off = {bus.req_addr[OFF_BITS-1:0], 3'b000} & ~((OFF_BITS+3)'(31));
  assign unused_addr = ^bus.req_addr[31:OFF_BITS+MEM_ADDR];

  assign hit       = bus.req_valid & valid_q[idx] & (tag_q[idx] == req_tag);
  assign hit_cmp   = (state_q == S_COMPARE) & hit;
  assign miss_cmp  = (state_q == S_COMPARE) & bus.req_valid & ~hit;
  assign store_hit = hit_cmp & bus.req_write;
  assign fill      = (state_q == S_ALLOCATE);

  assign bus.rd_data     = data_q[idx][bit_off +: 32];
  assign bus.mem_wr_data = data_q[idx];
  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;

  // State register plus per-line status and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_COMPARE;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays are never cleared; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && (fill || store_hit)) data_q[idx] <= line_d;
    if (!rst && fill)                tag_q[idx]  <= req_tag;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COMPARE:   if (miss_cmp) state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: state_d = S_ALLOCATE;
      S_ALLOCATE:  state_d = S_COMPARE;
      default:     state_d = S_COMPARE;
    endcase
  end

  // Outputs toward pipeline and memory.
  always_comb begin
    bus.stall     = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = {req_tag, idx};
    case (state_q)
      S_COMPARE:   bus.stall = bus.req_valid & ~hit;
      S_WRITEBACK: begin
        bus.stall     = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = {tag_q[idx], idx};
      end
      S_ALLOCATE:  bus.stall = 1'b1;
      default:     bus.stall = 1'b0;
    endcase
    // While in reset nothing completes, and no line may be written to memory.
    if (rst) begin
      bus.stall     = bus.req_valid;
      bus.mem_wr_en = 1'b0;
    end
  end

  // Line/status updates: refill replaces the whole line, a store hit merges enabled bytes.
  always_comb begin
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_d     = data_q[idx];
    hit_cnt_d  = hit_cnt_q + 32'(hit_cmp);
    miss_cnt_d = miss_cnt_q + 32'(miss_cmp);
    if (fill) begin
      line_d       = bus.mem_rd_data;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wstrb[b]) line_d[int'(bit_off) + 8*b +: 8] = bus.req_wdata[8*b +: 8];
      end
      // Set even with an all-zero strobe.
      dirty_d[idx] = 1'b1;
    end
  end

  req_stable_a: assert property (@(posedge clk) disable iff (rst)
    bus.stall |=> $stable({bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata, bus.req_wstrb}));

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized + directed bench for dcache_ctrl against a transaction-level cache model.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();
  dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // Backing memory seen by the DUT, and the model's own copy of what memory should hold.
  logic [127:0] mem     [64];
  logic [127:0] ref_mem [64];

  // Cache model: 8 lines, 16 bytes each.
  logic [127:0] m_line  [8];
  bit           m_valid [8];
  bit           m_dirty [8];
  int           m_tag   [8];
  logic [31:0]  m_hits, m_misses;

  int checks = 0;
  int errors = 0;

  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the completing edge.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    int idx, tg, w, stalls, wrs, wb_line;
    bit hit, dirty_v, done;
    logic [127:0] exp_wb, seen_wb_data;
    logic [5:0] seen_wb_addr, last_addr;
    logic [31:0] exp_rd;
    idx = int'(addr[6:4]);
    tg  = int'(addr[9:7]);
    w   = int'(addr[3:2]);
    hit     = m_valid[idx] && (m_tag[idx] == tg);
    dirty_v = !hit && m_valid[idx] && m_dirty[idx];
    exp_wb  = m_line[idx];
    wb_line = m_tag[idx] * 8 + idx;
    if (!hit) begin
      m_misses++;
      if (dirty_v) ref_mem[wb_line] = m_line[idx];
      m_line[idx]  = ref_mem[tg * 8 + idx];
      m_tag[idx]   = tg;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end
    m_hits++;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) m_line[idx][w*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[idx] = 1;
    end
    exp_rd = m_line[idx][w*32 +: 32];

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    stalls = 0; wrs = 0; done = 0;
    seen_wb_addr = '0; seen_wb_data = '0; last_addr = '0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        wrs++;
        seen_wb_addr = bus.mem_addr;
        seen_wb_data = bus.mem_wr_data;
      end
      if (bus.stall) begin
        stalls++;
        last_addr = bus.mem_addr;
        @(posedge clk);
        #1;
      end else begin
        done = 1;
      end
    end
    check("acc_timeout", done, 1);
    check("stall_cycles", stalls, hit ? 0 : (dirty_v ? 3 : 2));
    check("wb_count", wrs, dirty_v ? 1 : 0);
    if (dirty_v) begin
      check("wb_addr", seen_wb_addr, wb_line);
      check("wb_data", seen_wb_data, exp_wb);
    end
    if (!hit) check("alloc_addr", last_addr, tg * 8 + idx);
    if (!wr) check("rd_data", bus.rd_data, exp_rd);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("hit_count", bus.hit_count, m_hits);
    check("miss_count", bus.miss_count, m_misses);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_stall", bus.stall, 0);
    check("idle_wr_en", bus.mem_wr_en, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("reset_stall", bus.stall, 0);
    check("reset_wr_en", bus.mem_wr_en, 0);
    check("reset_hits", bus.hit_count, 0);
    check("reset_misses", bus.miss_count, 0);
    @(posedge clk);
    #1;

    // Clean miss after reset, then partial store hit and load-back.
    do_access(0, 32'h040, '0, '0);
    do_access(1, 32'h044, 32'hDEADBEEF, 4'b0101);
    do_access(0, 32'h044, '0, '0);

    // Store miss allocates and dirties line 0; conflicting load forces a writeback.
    do_access(1, 32'h000, 32'h12345678, 4'b1111);
    do_access(0, 32'h080, '0, '0);

    // Two clean misses from a fresh reset.
    do_reset();
    do_access(0, 32'h080, '0, '0);
    do_access(0, 32'h000, '0, '0);

    // Reset landing in the writeback cycle of a dirty miss.
    do_reset();
    do_access(1, 32'h000, 32'hA5A5_5A5A, 4'b1111);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h080;
    @(negedge clk);
    check("wbrst_cmp_stall", bus.stall, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wbrst_wr_en", bus.mem_wr_en, 1);
    check("wbrst_wb_addr", bus.mem_addr, 0);
    rst = 1'b1;
    #1;
    check("rst_held_stall", bus.stall, 1);
    check("rst_held_wr_en", bus.mem_wr_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    model_reset();
    check("wbrst_hits", bus.hit_count, 0);
    check("wbrst_misses", bus.miss_count, 0);
    check("wbrst_mem0", mem[0], ref_mem[0]);
    do_access(0, 32'h080, '0, '0);
    do_access(0, 32'h000, '0, '0);

    // Idle cycles leave everything unchanged.
    repeat (4) idle_cycle();
    check("idle_hits", bus.hit_count, m_hits);
    check("idle_misses", bus.miss_count, m_misses);

    // Random mix of loads, stores, idles and occasional resets.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) do_reset();
      else if (r < 20) idle_cycle();
      else do_access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
